// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pkg
//  Description : Shared types and segment constants for the multiplexed
//                seven-segment scan driver. Segment order is {g,f,e,d,c,b,a}
//                and all patterns are active-low.
//  Revision    : 1.0  initial release
// ============================================================================
package sevenseg_pkg;

  // One BCD digit as produced by a MOD10 decade counter stage
  typedef logic [3:0] bcd_t;

  // Dark and invalid-code patterns
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Digit patterns 0..9
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // True only for the code 0; invalid codes 10..15 count as nonzero so a
  // dash in an upper position keeps the digits below it visible.
  function automatic logic is_zero(input bcd_t d);
    return (d == 4'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : Combinational BCD to active-low seven-segment decoder.
//                Codes 10..15 produce a dash.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_7seg
  import sevenseg_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Table lookup; anything outside 0..9 falls through to the dash
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan_driver
//  Description : Time-multiplexed common-anode seven-segment driver. Captures
//                a BCD digit bus into a shadow register, scans digits with a
//                programmable dwell and one blanking cycle per slot, optional
//                leading-zero blanking, and a per-frame done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] digits,
  input  logic              load,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  // Scan state
  bcd_t [NDIG-1:0]  shadow;
  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;

  // Derived slot information, all from the pre-edge state
  logic [NDIG-1:0]  zero_from;   // bit k: shadow digits k..NDIG-1 are all zero
  bcd_t             sel_digit;
  logic [6:0]       dec_seg;
  logic             lz_blank;
  logic             slot_dark;
  logic             pre_last;
  logic             idx_last;

  // Suffix-AND of the per-digit zero flags, built from the top digit down
  generate
    for (genvar k = 0; k < NDIG; k++) begin : g_zero_from
      if (k == NDIG - 1) begin : g_top
        assign zero_from[k] = is_zero(shadow[k]);
      end else begin : g_lower
        assign zero_from[k] = is_zero(shadow[k]) & zero_from[k+1];
      end
    end
  endgenerate

  assign sel_digit = shadow[idx];
  assign pre_last  = (pre == PRE_LAST);
  assign idx_last  = (idx == IDX_LAST);

  // Digit 0 is always shown so a value of zero still reads "0"
  assign lz_blank  = blank_lz && (idx != '0) && zero_from[idx];
  assign slot_dark = (pre == '0) || lz_blank;

  // Single decoder shared by all digits, fed by the current scan position
  bcd_to_7seg u_dec (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

  // Shadow capture; the scan only ever reads this copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= digits;
    end
  end

  // Prescaler and digit index; the index steps at the last cycle of a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      if (pre_last) begin
        pre <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Registered outputs computed from the pre-edge scan state and shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      if (slot_dark) begin
        seg <= SEG_OFF;
        an  <= '1;
      end else begin
        seg <= dec_seg;
        an  <= ~(NDIG'(1) << idx);
      end
      frame_done <= pre_last && idx_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_sevenseg_scan_driver
//  Description : Self-checking bench for sevenseg_scan_driver (NDIG=4,
//                REFRESH_DIV=4). Expected outputs come from a cycle-count
//                model of the scan and a behavioural copy of the shadow.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sevenseg_scan_driver;

  localparam int NDIG = 4;
  localparam int RDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int passes = 0;

  // Model state: edges since reset and the digits the DUT should hold
  int n;
  int msh [NDIG];
  int fd_count;
  logic [6:0] dec_tbl [16];

  sevenseg_scan_driver #(.NDIG(NDIG), .REFRESH_DIV(RDIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    n = 0;
    for (int j = 0; j < NDIG; j++) msh[j] = 0;
  endtask

  // One clock: apply inputs, predict, clock, compare, update the model
  task automatic step(input logic ld, input logic [15:0] d, input logic blz);
    int p, i;
    logic lz, dark, efd;
    logic [3:0] ean;
    logic [6:0] eseg;
    load = ld; digits = d; blank_lz = blz;
    p = n % RDIV;
    i = (n / RDIV) % NDIG;
    lz = blz && (i >= 1);
    for (int j = i; j < NDIG; j++) if (msh[j] != 0) lz = 1'b0;
    dark = (p == 0) || lz;
    ean  = dark ? 4'hF : ~(4'b0001 << i);
    eseg = dark ? 7'h7F : dec_tbl[msh[i]];
    efd  = (p == RDIV - 1) && (i == NDIG - 1);
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(eseg));
    check("an", 32'(an), 32'(ean));
    check("frame_done", 32'(frame_done), 32'(efd));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    if (frame_done) fd_count++;
    if (ld) for (int j = 0; j < NDIG; j++) msh[j] = int'(d[4*j +: 4]);
    n++;
  endtask

  task automatic idle(input int cnt, input logic blz);
    for (int c = 0; c < cnt; c++) step(1'b0, 16'h0000, blz);
  endtask

  // Asynchronous reset pulse of 1 ns, placed between clock edges
  task automatic mid_reset();
    rst = 1'b1;
    #0.5;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_fd", 32'(frame_done), 32'd0);
    #0.5;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] rd;
    int k;
    dec_tbl[0] = 7'h40; dec_tbl[1] = 7'h79; dec_tbl[2] = 7'h24; dec_tbl[3] = 7'h30;
    dec_tbl[4] = 7'h19; dec_tbl[5] = 7'h12; dec_tbl[6] = 7'h02; dec_tbl[7] = 7'h78;
    dec_tbl[8] = 7'h00; dec_tbl[9] = 7'h10;
    for (int j = 10; j < 16; j++) dec_tbl[j] = 7'h3F;

    rst = 1'b1; load = 1'b0; digits = '0; blank_lz = 1'b0; fd_count = 0;
    model_reset();
    #2;
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_an", 32'(an), 32'hF);
    check("reset_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // 1234 with blanking off, two full frames after the load
    step(1'b1, 16'h1234, 1'b0);
    idle(32, 1'b0);

    // Leading-zero blanking on a single significant digit, then all zero
    step(1'b1, 16'h0007, 1'b1);
    idle(32, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle(16, 1'b1);

    // Invalid code above a valid one is shown as a dash, not blanked
    step(1'b1, 16'h00A5, 1'b1);
    idle(16, 1'b1);

    // Exactly one frame pulse per frame over five frames
    fd_count = 0;
    step(1'b1, 16'h4821, 1'b0);
    idle(79, 1'b0);
    check("fd_5frames", 32'(fd_count), 32'd5);

    // Reset in the middle of the digit-2 slot
    while ((n % 16) != 10) step(1'b0, 16'h0000, 1'b0);
    mid_reset();
    idle(2, 1'b0);
    check("post_rst_d0", 32'(seg), 32'h40);
    idle(14, 1'b0);

    // Load on the edge that closes the digit-0 slot
    mid_reset();
    idle(3, 1'b0);
    step(1'b1, 16'h9999, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("d1_blank_an", 32'(an), 32'hF);
    step(1'b0, 16'h0000, 1'b0);
    check("d1_first_seg", 32'(seg), 32'h10);
    check("d1_first_an", 32'(an), 32'hD);
    idle(12, 1'b0);

    // Randomized loads, blanking toggles and one extra async reset
    for (int s = 0; s < 400; s++) begin
      rd = 16'($urandom);
      k = int'($urandom % 5);
      for (int j = 0; j < NDIG; j++) if (j >= k) rd[4*j +: 4] = 4'h0;
      if (s == 200) mid_reset();
      step(($urandom % 8) == 0, rd, 1'($urandom % 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
